iob_cache_ctrl_seq: RTL and testbench

//  Initiator for the cache control register port. It turns one-word commands into sequences of

---
 rtl/iob_cache_ctrl_seq_if.sv | 30 +++
 rtl/iob_cache_ctrl_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_iob_cache_ctrl_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_ctrl_seq_if.sv
// Command and control-port bundle for the cache control sequencer.
// master = sequencer side, slave = CSR logic plus cache control slave.
`ifndef iob_cache_swreg_ADDR_W
`define iob_cache_swreg_ADDR_W 5
`endif

interface iob_cache_ctrl_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = `iob_cache_swreg_ADDR_W
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic              done;
    logic              err;
    logic              ctrl_valid;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              ctrl_ready;

    modport master (
        input  cmd_valid, cmd, ctrl_rdata, ctrl_ready,
        output cmd_ready, done, err, ctrl_valid, ctrl_addr
    );

    modport slave (
        output cmd_valid, cmd, ctrl_rdata, ctrl_ready,
        input  cmd_ready, done, err, ctrl_valid, ctrl_addr
    );
endinterface

// File: rtl/iob_cache_ctrl_seq.sv
// Cache control-port sequencer: turns one-word commands into
// single-cycle control requests and collects registered responses.
`ifndef iob_cache_swreg_ADDR_W
`define iob_cache_swreg_ADDR_W 5
`endif
`ifndef CACHE_WTB_EMPTY_ADDR
`define CACHE_WTB_EMPTY_ADDR 1
`endif
`ifndef CACHE_READ_HIT_ADDR
`define CACHE_READ_HIT_ADDR 2
`endif
`ifndef CACHE_READ_MISS_ADDR
`define CACHE_READ_MISS_ADDR 3
`endif
`ifndef CACHE_WRITE_HIT_ADDR
`define CACHE_WRITE_HIT_ADDR 4
`endif
`ifndef CACHE_WRITE_MISS_ADDR
`define CACHE_WRITE_MISS_ADDR 5
`endif
`ifndef CACHE_RST_CNTRS_ADDR
`define CACHE_RST_CNTRS_ADDR 6
`endif
`ifndef CACHE_INVALIDATE_ADDR
`define CACHE_INVALIDATE_ADDR 7
`endif
`ifndef CACHE_VERSION_ADDR
`define CACHE_VERSION_ADDR 8
`endif

module iob_cache_ctrl_seq #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = `iob_cache_swreg_ADDR_W,
    parameter int POLL_MAX = 1024,
    parameter int RSP_TMO  = 8
) (
    input  logic                clk,
    input  logic                reset,
    iob_cache_ctrl_seq_if.master bus,
    output logic [DATA_W-1:0]   snap_rhit,
    output logic [DATA_W-1:0]   snap_rmiss,
    output logic [DATA_W-1:0]   snap_whit,
    output logic [DATA_W-1:0]   snap_wmiss,
    output logic [DATA_W-1:0]   version
);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int TW = $clog2(RSP_TMO + 1);

    localparam logic [1:0] C_SNAP  = 2'd0;
    localparam logic [1:0] C_FLUSH = 2'd1;
    localparam logic [1:0] C_CLEAR = 2'd2;
    localparam logic [1:0] C_VER   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [1:0]        step_q, step_d;
    logic [PW-1:0]     poll_q, poll_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] sh_q [4];
    logic [DATA_W-1:0] sh_d [4];
    logic [DATA_W-1:0] ver_sh_q, ver_sh_d;
    logic              fail;

    logic              cmd_ready_q, cmd_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic [ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DATA_W-1:0] snap_q [4];
    logic [DATA_W-1:0] snap_d [4];
    logic [DATA_W-1:0] version_q, version_d;

    function automatic logic [ADDR_W-1:0] step_addr(
        input logic [1:0] c,
        input logic [1:0] s
    );
        logic [ADDR_W-1:0] a;
        a = '0;
        case (c)
            C_SNAP: begin
                case (s)
                    2'd0: a = ADDR_W'(`CACHE_READ_HIT_ADDR);
                    2'd1: a = ADDR_W'(`CACHE_READ_MISS_ADDR);
                    2'd2: a = ADDR_W'(`CACHE_WRITE_HIT_ADDR);
                    default: a = ADDR_W'(`CACHE_WRITE_MISS_ADDR);
                endcase
            end
            C_FLUSH: a = (s == 2'd0) ? ADDR_W'(`CACHE_WTB_EMPTY_ADDR)
                                     : ADDR_W'(`CACHE_INVALIDATE_ADDR);
            C_CLEAR: a = ADDR_W'(`CACHE_RST_CNTRS_ADDR);
            default: a = ADDR_W'(`CACHE_VERSION_ADDR);
        endcase
        return a;
    endfunction

    // State, step bookkeeping and response shadows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            step_q   <= '0;
            poll_q   <= '0;
            tmo_q    <= '0;
            ver_sh_q <= '0;
            for (int i = 0; i < 4; i++) sh_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            step_q   <= step_d;
            poll_q   <= poll_d;
            tmo_q    <= tmo_d;
            ver_sh_q <= ver_sh_d;
            for (int i = 0; i < 4; i++) sh_q[i] <= sh_d[i];
        end
    end

    // Next state: step sequencing, poll limit and response timeout
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        step_d   = step_q;
        poll_d   = poll_q;
        tmo_d    = tmo_q;
        ver_sh_d = ver_sh_q;
        sh_d     = sh_q;
        fail     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd;
                    step_d  = '0;
                    poll_d  = '0;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ctrl_ready) begin
                    tmo_d = '0;
                    case (cmd_q)
                        C_SNAP: begin
                            sh_d[step_q] = bus.ctrl_rdata;
                            if (step_q == 2'd3) begin
                                state_d = S_DONE;
                            end else begin
                                step_d  = step_q + 2'd1;
                                state_d = S_ISSUE;
                            end
                        end
                        C_FLUSH: begin
                            if (step_q != 2'd0) begin
                                state_d = S_DONE;
                            end else if (bus.ctrl_rdata[0]) begin
                                step_d  = 2'd1;
                                state_d = S_ISSUE;
                            end else begin
                                poll_d = poll_q + PW'(1);
                                if (poll_q >= PW'(POLL_MAX - 1)) begin
                                    fail    = 1'b1;
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_ISSUE;
                                end
                            end
                        end
                        C_CLEAR: state_d = S_DONE;
                        default: begin
                            ver_sh_d = bus.ctrl_rdata;
                            state_d  = S_DONE;
                        end
                    endcase
                end else if (tmo_q >= TW'(RSP_TMO - 1)) begin
                    fail    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        cmd_ready_d  = (state_d == S_IDLE);
        done_d       = (state_d == S_DONE);
        err_d        = done_d & fail;
        ctrl_valid_d = (state_d == S_ISSUE);
        ctrl_addr_d  = ctrl_addr_q;
        snap_d       = snap_q;
        version_d    = version_q;
        if (ctrl_valid_d) ctrl_addr_d = step_addr(cmd_d, step_d);
        if (state_q == S_DONE && !err_q) begin
            if (cmd_q == C_SNAP) snap_d = sh_q;
            if (cmd_q == C_VER) version_d = ver_sh_q;
        end
    end

    // Output register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ctrl_valid_q <= 1'b0;
            ctrl_addr_q  <= '0;
            version_q    <= '0;
            for (int i = 0; i < 4; i++) snap_q[i] <= '0;
        end else begin
            cmd_ready_q  <= cmd_ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_addr_q  <= ctrl_addr_d;
            version_q    <= version_d;
            for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.ctrl_addr  = ctrl_addr_q;
    assign snap_rhit      = snap_q[0];
    assign snap_rmiss     = snap_q[1];
    assign snap_whit      = snap_q[2];
    assign snap_wmiss     = snap_q[3];
    assign version        = version_q;
endmodule

// File: tb/tb_iob_cache_ctrl_seq.sv
// Directed bench for iob_cache_ctrl_seq with a 1-cycle
// registered control slave model.
module tb_iob_cache_ctrl_seq;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [4:0] ARH = 5'd2, ARM = 5'd3, AWH = 5'd4, AWM = 5'd5;
    localparam logic [4:0] AWTB = 5'd1, ARST = 5'd6, AINV = 5'd7, AVER = 5'd8;
    localparam logic [31:0] VERV = 32'h0102_0304;

    typedef struct {
        logic [1:0]      cmd;
        int              ne;
        logic            mute;
        int              lat;
        logic            err;
        int              nv;
        logic [7:0][4:0] a;
        logic [31:0]     rh, rm, wh, wm, ver;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DW-1:0] snap_rhit, snap_rmiss, snap_whit, snap_wmiss, version;

    iob_cache_ctrl_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    iob_cache_ctrl_seq #(
        .DATA_W(DW), .ADDR_W(AW), .POLL_MAX(4), .RSP_TMO(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .snap_rhit(snap_rhit), .snap_rmiss(snap_rmiss),
        .snap_whit(snap_whit), .snap_wmiss(snap_wmiss),
        .version(version)
    );

    always #5 clk = ~clk;

    // slave model
    logic        mute = 1'b0;
    logic        stray_rdy = 1'b0;
    logic [31:0] stray_data = '0;
    logic        rdy_r = 1'b0;
    logic [31:0] rdata_r = '0;
    int          poll_seen = 0;
    int          ne_lim = 0;
    int          rsp_cnt = 0;
    int          b2b = 0;
    int          done_cnt = 0;
    logic        prev_v = 1'b0;
    logic [4:0]  vlog[$];

    assign bus.ctrl_ready = rdy_r | stray_rdy;
    assign bus.ctrl_rdata = stray_rdy ? stray_data : rdata_r;

    always @(posedge clk) begin
        rdy_r <= 1'b0;
        if (bus.ctrl_valid && !mute) begin
            rdy_r   <= 1'b1;
            rsp_cnt <= rsp_cnt + 1;
            case (bus.ctrl_addr)
                ARH: rdata_r <= 32'd5;
                ARM: rdata_r <= 32'd2;
                AWH: rdata_r <= 32'd7;
                AWM: rdata_r <= 32'd1;
                AVER: rdata_r <= VERV;
                AWTB: begin
                    rdata_r   <= (poll_seen >= ne_lim) ? 32'd1 : 32'd0;
                    poll_seen <= poll_seen + 1;
                end
                default: rdata_r <= 32'hFFFF_FFFE;
            endcase
        end
        if (bus.ctrl_valid) begin
            vlog.push_back(bus.ctrl_addr);
            if (prev_v) b2b <= b2b + 1;
        end
        prev_v <= bus.ctrl_valid;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_rh = 0, cur_rm = 0, cur_wh = 0, cur_wm = 0, cur_ver = 0;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] c, input int ne, input logic m,
                                input int lat, input logic e, input int nv,
                                input logic [7:0][4:0] a, input logic [31:0] ver);
        vec_t v;
        v.cmd = c; v.ne = ne; v.mute = m; v.lat = lat; v.err = e;
        v.nv = nv; v.a = a; v.ver = ver;
        v.rh = 32'd5; v.rm = 32'd2; v.wh = 32'd7; v.wm = 32'd1;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        int base, lat;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        mute = v.mute;
        ne_lim = poll_seen + v.ne;
        base = vlog.size();
        chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd = v.cmd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        chk({p, "_latency"}, 32'(lat), 32'(v.lat));
        chk({p, "_err"}, 32'(bus.err), 32'(v.err));
        chk({p, "_ready_in_done"}, 32'(bus.cmd_ready), 32'd0);
        chk({p, "_rhit_pre"}, snap_rhit, cur_rh);
        chk({p, "_wmiss_pre"}, snap_wmiss, cur_wm);
        @(negedge clk);
        chk({p, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({p, "_nvalid"}, 32'(vlog.size() - base), 32'(v.nv));
        for (int i = 0; i < v.nv && i < 8; i++) begin
            if (base + i < vlog.size())
                chk($sformatf("%s_addr%0d", p, i), 32'(vlog[base + i]), 32'(v.a[i]));
        end
        chk({p, "_rhit"}, snap_rhit, v.rh);
        chk({p, "_rmiss"}, snap_rmiss, v.rm);
        chk({p, "_whit"}, snap_whit, v.wh);
        chk({p, "_wmiss"}, snap_wmiss, v.wm);
        chk({p, "_version"}, version, v.ver);
        cur_rh = v.rh; cur_rm = v.rm; cur_wh = v.wh; cur_wm = v.wm;
        cur_ver = v.ver;
        mute = 1'b0;
    endtask

    initial begin
        int base, d0;
        bit found;
        bus.cmd_valid = 1'b0;
        bus.cmd = 2'd0;
        // addresses are listed last-to-first in the packed array
        vt[0] = mk(2'd0, 0, 1'b0, 9, 1'b0, 4, {5'd0, 5'd0, 5'd0, 5'd0, AWM, AWH, ARM, ARH}, 32'd0);
        vt[1] = mk(2'd1, 3, 1'b0, 11, 1'b0, 5, {5'd0, 5'd0, 5'd0, AINV, AWTB, AWTB, AWTB, AWTB}, 32'd0);
        vt[2] = mk(2'd1, 1000, 1'b0, 9, 1'b1, 4, {5'd0, 5'd0, 5'd0, 5'd0, AWTB, AWTB, AWTB, AWTB}, 32'd0);
        // valid in cycle 1, eight silent WAIT cycles, done in cycle 10
        vt[3] = mk(2'd3, 0, 1'b1, 10, 1'b1, 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, AVER}, 32'd0);
        vt[4] = mk(2'd2, 0, 1'b0, 3, 1'b0, 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, ARST}, 32'd0);
        vt[5] = mk(2'd3, 0, 1'b0, 3, 1'b0, 1, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, AVER}, VERV);
        vt[6] = mk(2'd1, 0, 1'b0, 5, 1'b0, 2, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, AINV, AWTB}, VERV);

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_addr", 32'(bus.ctrl_addr), 32'd0);
        chk("rst_snap", snap_rhit | snap_rmiss | snap_whit | snap_wmiss, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_err", 32'(bus.err), 32'd0);
        chk("post_rst_version", version, 32'd0);

        for (int i = 0; i < 7; i++) run(vt[i], i);

        // reset in the middle of a snapshot
        base = rsp_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_cnt - base >= 2 && bus.ctrl_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_rst_reached", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.ctrl_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        base = vlog.size();
        d0 = done_cnt;
        stray_data = 32'h5555_5555;
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_nvalid", 32'(vlog.size() - base), 32'd0);
        chk("mid_rst_ndone", 32'(done_cnt - d0), 32'd0);
        chk("mid_rst_rhit", snap_rhit, 32'd0);
        chk("mid_rst_rmiss", snap_rmiss, 32'd0);
        chk("mid_rst_version", version, 32'd0);
        chk("mid_rst_idle", 32'(bus.cmd_ready), 32'd1);

        // stray readies in IDLE, command pulses while busy
        base = vlog.size();
        d0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            stray_rdy = 1'b1;
            @(negedge clk);
            stray_rdy = 1'b0;
            @(negedge clk);
        end
        chk("idle_rdy_nvalid", 32'(vlog.size() - base), 32'd0);
        chk("idle_rdy_ndone", 32'(done_cnt - d0), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd = 2'd0;
        @(negedge clk);
        bus.cmd = 2'd3;
        for (int c = 1; c <= 7; c++) begin
            bus.cmd_valid = c[0];
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_nvalid", 32'(vlog.size() - base), 32'd4);
        if (vlog.size() - base == 4) begin
            chk("busy_a0", 32'(vlog[base]), 32'(ARH));
            chk("busy_a3", 32'(vlog[base + 3]), 32'(AWM));
        end
        chk("busy_ndone", 32'(done_cnt - d0), 32'd1);
        chk("busy_rhit", snap_rhit, 32'd5);
        chk("busy_wmiss", snap_wmiss, 32'd1);
        chk("no_b2b_valid", 32'(b2b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
